rs_codeword_buffer: RTL and testbench
=====================================

Name: rs_codeword_buffer

Overview:
Double-banked input buffer directly upstream of the RS(255,223) syndrome unit. Accepts received bytes from the channel and stores each 255-byte codeword. Streams every complete codeword to the syndrome unit on new_data/recd/decoder_rd_addr. Holds the codeword until the downstream error-correction stage has read it and released the bank.

Parameters:
DATA_W, 8, symbol width in bits.
CW_LEN, 255, symbols per codeword.
ADDR_W, 8, width of the stream and correction addresses.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
in_valid  in  1  input byte valid.
in_data  in  DATA_W  received byte; first byte is the highest-degree coefficient.
in_ready  out  1  buffer can accept in_data this cycle.
new_data  out  1  recd/decoder_rd_addr valid to the syndrome unit.
recd  out  DATA_W  codeword byte to the syndrome unit.
decoder_rd_addr  out  ADDR_W  1-based byte index, 1..CW_LEN.
stream_done  out  1  one-cycle pulse after the last byte of a codeword is streamed.
corr_valid  out  1  a streamed codeword is held for correction.
corr_rd_addr  in  ADDR_W  0-based read index into the held codeword.
corr_rd_data  out  DATA_W  held byte; registered, 1-cycle latency.
corr_release  in  1  frees the held bank (one-cycle pulse).

Behaviour:
- Reset (interface): reset is synchronous, active-high, on clock.
- Storage: two banks of CW_LEN x DATA_W. Each bank has a state: FREE, FILLING, FULL, STREAMING, HELD.
- Reset effect: both banks FREE; write bank 0; write count 0; stream FSM IDLE.
- Reset output values: in_ready=1, new_data=0, recd=0, decoder_rd_addr=0, stream_done=0, corr_valid=0, corr_rd_data=0.
- Reset mid-operation discards all stored and partial data. No pulses are emitted.
- Write side: a byte is accepted when in_valid and in_ready. It is stored at the write count and the count increments.
  - The bank goes FILLING on its first byte.
  - On the CW_LEN-th byte: bank becomes FULL, count returns to 0, write bank toggles.
  - in_ready=1 only while the write bank is FREE or FILLING.
  - in_ready is registered. It reflects bank state from the previous edge.
- Stream FSM states: IDLE, STREAM.
  - IDLE -> STREAM: when a FULL bank exists. If both banks are FULL, take the older one (tracked by a 1-bit order flag). That bank becomes STREAMING.
  - STREAM: one byte per cycle, no gaps. new_data=1, decoder_rd_addr = k, recd = mem[k-1], for k=1..CW_LEN.
  - Stream latency: first new_data appears 2 cycles after the edge that made the bank FULL. This comprises 1 cycle FSM decision and 1 cycle RAM read; address and data are registered together so they stay aligned.
  - After k=CW_LEN: new_data=0 and decoder_rd_addr=0 the next cycle. stream_done pulses that same cycle. The bank becomes HELD and the FSM returns to IDLE.
  - A second FULL bank can start streaming at the earliest on the cycle after stream_done.
- Correction side:
  - corr_valid=1 while any bank is HELD. It points to the oldest HELD bank.
  - corr_rd_data = mem[corr_rd_addr] of that bank, one cycle later.
  - corr_rd_addr >= CW_LEN returns 0.
  - corr_release with corr_valid: that bank becomes FREE on the next edge.
  - corr_release without corr_valid is ignored.
- Simultaneous events:
  - Release and write-complete on the same edge: both take effect.
  - A released bank may become the write bank in the same cycle; in_ready rises the following cycle.
  - At most one bank streams at a time. Both banks may be HELD; in_ready=0 until a release.
- Ordering: codewords are streamed and held strictly in arrival order.

Decomposition:
- Package rs_pkg: DATA_W, CW_LEN, ADDR_W, and the bank-state enum (FREE/FILLING/FULL/STREAMING/HELD), shared with the syndrome and correction stages.
- One sub-module, rs_bank_ram: single CW_LEN x DATA_W RAM with one write port and one registered read port, instantiated twice.
- The correction read path uses a separate read mux of the two bank outputs, with the read address muxed per bank.

Test Plan:
- Single codeword, bytes 0x01..0xFF, in_valid held high -> new_data high for exactly 255 consecutive cycles; decoder_rd_addr 1..255 paired with recd 0x01..0xFF; stream_done pulses once; corr_valid=1.
- With a codeword held, read corr_rd_addr 0, 10, 254 -> corr_rd_data 0x01, 0x0B, 0xFF one cycle later; corr_rd_addr 255 -> 0x00.
- Three back-to-back codewords with no release -> in_ready drops after the 510th accepted byte; pulsing corr_release restores in_ready; the third codeword then streams with correct data.
- Release on the same edge as the last write of the other bank -> no byte lost; both bank states correct; the next in_ready asserts one cycle later.
- Assert reset at stream index 100 -> next cycle all outputs are at reset values and in_ready=1; a fresh codeword then streams from decoder_rd_addr=1.
- Gapped input (in_valid toggling 1/0) -> stream still starts 2 cycles after the 255th accepted byte with no gaps in new_data.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared symbol geometry and state types for the RS(255,223) receive path
// (input buffer, syndrome unit and correction stage).
package rs_pkg;

  localparam int DATA_W = 8;
  localparam int CW_LEN = 255;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    FREE,
    FILLING,
    FULL,
    STREAMING,
    HELD
  } bank_state_t;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } strm_state_t;

endpackage

// File: rtl/rs_bank_ram.sv
// One codeword bank: single write port, single registered read port.
module rs_bank_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 255,
  parameter int AW    = 8
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rs_codeword_buffer.sv
// Double-banked codeword buffer feeding the syndrome unit and holding each codeword for correction.
//   ST_IDLE   | waiting for the next-in-order bank to be FULL
//   ST_STREAM | issuing one RAM read per cycle, index 0..CW_LEN-1
module rs_codeword_buffer
  import rs_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              new_data,
  output logic [DATA_W-1:0] recd,
  output logic [ADDR_W-1:0] decoder_rd_addr,
  output logic              stream_done,
  output logic              corr_valid,
  input  logic [ADDR_W-1:0] corr_rd_addr,
  output logic [DATA_W-1:0] corr_rd_data,
  input  logic              corr_release
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CW_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(CW_LEN);

  bank_state_t bank_state [2];
  bank_state_t bank_next  [2];

  logic              wr_bank, wr_bank_next, wr_en, wr_last;
  logic [ADDR_W-1:0] wr_cnt;

  strm_state_t       strm_state, strm_next;
  logic              strm_ptr, strm_bank, strm_start, streaming, strm_fin;
  logic [ADDR_W-1:0] rd_idx;

  logic              corr_ptr, corr_sel, corr_rd_ok, corr_rel;

  logic [ADDR_W-1:0] rd_addr0, rd_addr1;
  logic [DATA_W-1:0] rd_data0, rd_data1;

  assign wr_en        = in_valid && in_ready;
  assign wr_last      = wr_en && (wr_cnt == LAST_IDX);
  assign wr_bank_next = wr_last ? ~wr_bank : wr_bank;
  assign corr_valid   = (bank_state[corr_ptr] == HELD);
  assign corr_rel     = corr_release && corr_valid;
  assign strm_fin     = new_data && (decoder_rd_addr == LAST_K);

  // The streaming bank reads at the stream index; the other bank serves correction reads.
  assign rd_addr0 = (streaming && !strm_bank) ? rd_idx : corr_rd_addr;
  assign rd_addr1 = (streaming &&  strm_bank) ? rd_idx : corr_rd_addr;

  rs_bank_ram #(.WIDTH(DATA_W), .DEPTH(CW_LEN), .AW(ADDR_W)) u_ram0 (
    .clock   (clock),
    .wr_en   (wr_en && !wr_bank),
    .wr_addr (wr_cnt),
    .wr_data (in_data),
    .rd_addr (rd_addr0),
    .rd_data (rd_data0)
  );

  rs_bank_ram #(.WIDTH(DATA_W), .DEPTH(CW_LEN), .AW(ADDR_W)) u_ram1 (
    .clock   (clock),
    .wr_en   (wr_en && wr_bank),
    .wr_addr (wr_cnt),
    .wr_data (in_data),
    .rd_addr (rd_addr1),
    .rd_data (rd_data1)
  );

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_next[b] = bank_state[b];
      if (wr_en && (wr_bank == 1'(b)))        bank_next[b] = wr_last ? FULL : FILLING;
      if (strm_start && (strm_ptr == 1'(b)))  bank_next[b] = STREAMING;
      if (strm_fin && (strm_bank == 1'(b)))   bank_next[b] = HELD;
      if (corr_rel && (corr_ptr == 1'(b)))    bank_next[b] = FREE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) strm_state <= ST_IDLE;
    else       strm_state <= strm_next;
  end

  always_comb begin
    strm_next = strm_state;
    case (strm_state)
      ST_IDLE:   if (bank_state[strm_ptr] == FULL) strm_next = ST_STREAM;
      ST_STREAM: if (rd_idx == LAST_IDX)           strm_next = ST_IDLE;
      default:   strm_next = ST_IDLE;
    endcase
  end

  always_comb begin
    streaming  = (strm_state == ST_STREAM);
    strm_start = (strm_state == ST_IDLE) && (bank_state[strm_ptr] == FULL);
  end

  // Banks fill, stream and release strictly alternately, so one pointer per side tracks age.
  always_ff @(posedge clock) begin
    if (reset) begin
      bank_state[0]   <= FREE;
      bank_state[1]   <= FREE;
      wr_bank         <= 1'b0;
      wr_cnt          <= '0;
      in_ready        <= 1'b1;
      strm_ptr        <= 1'b0;
      strm_bank       <= 1'b0;
      rd_idx          <= '0;
      new_data        <= 1'b0;
      decoder_rd_addr <= '0;
      stream_done     <= 1'b0;
      corr_ptr        <= 1'b0;
      corr_sel        <= 1'b0;
      corr_rd_ok      <= 1'b0;
    end else begin
      bank_state[0] <= bank_next[0];
      bank_state[1] <= bank_next[1];
      if (wr_en) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      wr_bank  <= wr_bank_next;
      in_ready <= (bank_next[wr_bank_next] == FREE) || (bank_next[wr_bank_next] == FILLING);
      if (strm_start) begin
        strm_bank <= strm_ptr;
        strm_ptr  <= ~strm_ptr;
        rd_idx    <= '0;
      end else if (streaming) begin
        rd_idx <= rd_idx + 1'b1;
      end
      new_data        <= streaming;
      decoder_rd_addr <= streaming ? rd_idx + 1'b1 : '0;
      stream_done     <= strm_fin;
      if (corr_rel) corr_ptr <= ~corr_ptr;
      corr_sel   <= corr_ptr;
      corr_rd_ok <= corr_valid && (corr_rd_addr < LAST_K);
    end
  end

  assign recd         = new_data   ? (strm_bank ? rd_data1 : rd_data0) : '0;
  assign corr_rd_data = corr_rd_ok ? (corr_sel  ? rd_data1 : rd_data0) : '0;

endmodule

// File: tb/tb_rs_codeword_buffer.sv
// Randomized bench for rs_codeword_buffer against a codeword-queue reference model.
module tb_rs_codeword_buffer;
  import rs_pkg::*;

  logic              clock = 1'b0;
  logic              reset, in_valid, in_ready, new_data, stream_done, corr_valid, corr_release;
  logic [DATA_W-1:0] in_data, recd, corr_rd_data;
  logic [ADDR_W-1:0] decoder_rd_addr, corr_rd_addr;

  rs_codeword_buffer dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .new_data        (new_data),
    .recd            (recd),
    .decoder_rd_addr (decoder_rd_addr),
    .stream_done     (stream_done),
    .corr_valid      (corr_valid),
    .corr_rd_addr    (corr_rd_addr),
    .corr_rd_data    (corr_rd_data),
    .corr_release    (corr_release)
  );

  always #5 clock = ~clock;

  typedef logic [DATA_W-1:0] cw_t [CW_LEN];

  // Reference model: completed codewords since reset, the edge on which each
  // starts streaming, and how many have been released.
  cw_t  cws[$];
  cw_t  part;
  int   part_cnt, rel_cnt, cyc;
  int   t_start[$];
  logic exp_in_ready, exp_new_data, exp_stream_done, exp_corr_valid;
  logic [DATA_W-1:0] exp_recd, exp_corr_rd_data;
  logic [ADDR_W-1:0] exp_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int nd_cnt, sd_cnt;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    int held;
    if (reset) begin
      cws.delete();
      t_start.delete();
      part_cnt = 0;
      rel_cnt  = 0;
      exp_in_ready = 1'b1; exp_new_data = 1'b0; exp_addr = '0; exp_recd = '0;
      exp_stream_done = 1'b0; exp_corr_valid = 1'b0; exp_corr_rd_data = '0;
      return;
    end
    if (exp_corr_valid && int'(corr_rd_addr) < CW_LEN) exp_corr_rd_data = cws[rel_cnt][corr_rd_addr];
    else                                                 exp_corr_rd_data = '0;
    if (in_valid && exp_in_ready) begin
      part[part_cnt] = in_data;
      part_cnt++;
      if (part_cnt == CW_LEN) begin
        int t;
        t = cyc + 2;
        if (t_start.size() > 0 && t_start[$] + CW_LEN + 1 > t) t = t_start[$] + CW_LEN + 1;
        cws.push_back(part);
        t_start.push_back(t);
        part_cnt = 0;
      end
    end
    if (corr_release && exp_corr_valid) rel_cnt++;
    exp_new_data = 1'b0; exp_addr = '0; exp_recd = '0; exp_stream_done = 1'b0;
    held = 0;
    foreach (t_start[i]) begin
      if (cyc >= t_start[i] && cyc < t_start[i] + CW_LEN) begin
        exp_new_data = 1'b1;
        exp_addr     = ADDR_W'(cyc - t_start[i] + 1);
        exp_recd     = cws[i][cyc - t_start[i]];
      end
      if (cyc == t_start[i] + CW_LEN) exp_stream_done = 1'b1;
      if (cyc >= t_start[i] + CW_LEN) held++;
    end
    exp_corr_valid = (held - rel_cnt) > 0;
    exp_in_ready   = (part_cnt > 0) || (cws.size() - rel_cnt < 2);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    model_edge();
    if (new_data)    nd_cnt++;
    if (stream_done) sd_cnt++;
    check_val("in_ready",        32'(in_ready),        32'(exp_in_ready));
    check_val("new_data",        32'(new_data),        32'(exp_new_data));
    check_val("decoder_rd_addr", 32'(decoder_rd_addr), 32'(exp_addr));
    check_val("recd",            32'(recd),            32'(exp_recd));
    check_val("stream_done",     32'(stream_done),     32'(exp_stream_done));
    check_val("corr_valid",      32'(corr_valid),      32'(exp_corr_valid));
    check_val("corr_rd_data",    32'(corr_rd_data),    32'(exp_corr_rd_data));
  endtask

  task automatic idle(input int n);
    in_valid     = 1'b0;
    corr_release = 1'b0;
    repeat (n) step();
  endtask

  task automatic release_pulse();
    corr_release = 1'b1;
    step();
    corr_release = 1'b0;
  endtask

  // Offers bytes until n have been accepted (by the model's view of in_ready).
  task automatic feed(input int n, input bit gapped, input bit seq);
    int got    = 0;
    int budget = 0;
    while (got < n && budget < 4000) begin
      in_valid = gapped ? (budget % 2 == 0) : 1'b1;
      in_data  = seq ? DATA_W'(got + 1) : DATA_W'($urandom);
      if (in_valid && exp_in_ready) got++;
      step();
      budget++;
    end
    in_valid = 1'b0;
    if (got < n) check_val("feed_timeout", 32'(got), 32'(n));
  endtask

  task automatic wait_held();
    int b = 0;
    while (!exp_corr_valid && b < 1000) begin
      step();
      b++;
    end
    if (!exp_corr_valid) check_val("held_timeout", 32'(corr_valid), 32'd1);
  endtask

  initial begin
    int ra[4];
    int rv[4];
    int f_cyc, b;
    bit seen;
    ra = '{0, 10, 254, 255};
    rv = '{8'h01, 8'h0B, 8'hFF, 8'h00};
    cyc = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; corr_release = 1'b0; corr_rd_addr = '0;
    step();
    step();
    reset = 1'b0;
    check_val("rst_in_ready",  32'(in_ready),        32'd1);
    check_val("rst_new_data",  32'(new_data),        32'd0);
    check_val("rst_addr",      32'(decoder_rd_addr), 32'd0);
    check_val("rst_corr_valid",32'(corr_valid),      32'd0);

    // Single codeword 0x01..0xFF
    nd_cnt = 0; sd_cnt = 0;
    feed(CW_LEN, 1'b0, 1'b1);
    idle(270);
    check_val("cw0_new_data_cycles", 32'(nd_cnt), 32'd255);
    check_val("cw0_stream_done_cnt", 32'(sd_cnt), 32'd1);
    check_val("cw0_corr_valid",      32'(corr_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      corr_rd_addr = ADDR_W'(ra[i]);
      step();
      check_val("corr_rd_directed", 32'(corr_rd_data), 32'(rv[i]));
    end
    release_pulse();
    check_val("cw0_released", 32'(corr_valid), 32'd0);

    // Three codewords with no release: buffer fills after 510 bytes
    feed(2 * CW_LEN, 1'b0, 1'b0);
    check_val("ready_drop_510", 32'(in_ready), 32'd0);
    idle(600);
    check_val("both_held_ready", 32'(in_ready), 32'd0);
    release_pulse();
    check_val("ready_after_release", 32'(in_ready), 32'd1);
    feed(CW_LEN, 1'b0, 1'b0);
    idle(600);
    for (int i = 0; i < 3; i++) begin
      release_pulse();
      idle(3);
    end

    // Release on the same edge as the other bank's last write
    feed(CW_LEN, 1'b0, 1'b0);
    feed(CW_LEN - 1, 1'b0, 1'b0);
    wait_held();
    in_valid = 1'b1; in_data = DATA_W'($urandom); corr_release = 1'b1;
    step();
    in_valid = 1'b0; corr_release = 1'b0;
    check_val("coinc_in_ready",   32'(in_ready),   32'd1);
    check_val("coinc_corr_valid", 32'(corr_valid), 32'd0);
    idle(600);
    release_pulse();

    // Reset in the middle of a stream, then a gapped codeword
    feed(CW_LEN, 1'b0, 1'b0);
    b = 0;
    while (exp_addr != 100 && b < 400) begin
      step();
      b++;
    end
    check_val("reached_idx100", 32'(decoder_rd_addr), 32'd100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("mid_rst_new_data", 32'(new_data),        32'd0);
    check_val("mid_rst_addr",     32'(decoder_rd_addr), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready),        32'd1);
    feed(CW_LEN, 1'b1, 1'b0);
    f_cyc = cyc;
    seen  = 1'b0;
    b = 0;
    while (!seen && b < 600) begin
      step();
      b++;
      if (new_data) begin
        seen = 1'b1;
        check_val("restart_addr", 32'(decoder_rd_addr), 32'd1);
        check_val("gap_latency",  32'(cyc - f_cyc),     32'd2);
      end
    end
    if (!seen) check_val("restart_timeout", 32'(new_data), 32'd1);
    idle(300);
    release_pulse();

    // Random traffic
    repeat (4000) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_data      = DATA_W'($urandom);
      corr_release = ($urandom_range(0, 40) == 0);
      corr_rd_addr = ADDR_W'($urandom_range(0, 255));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
